// File: rtl/adaptive_filter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// adaptive_filter_pkg
// Shared definitions for the adaptive filter slice: the Q8.6 sample format,
// the two filter modes and the sequencer state encoding. Used by the
// controller, its stream interface and anything that talks to the filter.
// ---------------------------------------------------------------------------
package adaptive_filter_pkg;

  // Q8.6 signed fixed point: 14 bits total, 6 of them fractional.
  localparam int Q_WIDTH = 14;
  localparam int Q_FRAC  = 6;

  // Filter mode encoding as seen on the filter's ctrl pin.
  localparam logic MODE_DIFF = 1'b0;
  localparam logic MODE_INT  = 1'b1;

  // Sequencer states: FLUSH holds the filter in reset, RUN streams samples,
  // DRAIN lets already accepted samples leave before a mode switch.
  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrlState_e;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adaptive_filter_ctrl_if.sv
// ---------------------------------------------------------------------------
// adaptive_filter_ctrl_if
// Bundles every non-clock signal of the filter sequencer.
//   master : the sequencer (drives s_tready, m_*, flt_* outputs, status)
//   slave  : its surroundings (sample source, sink, requester, filter)
// Signals:
//   mode_req_valid/mode_req/mode_req_ready : mode-change request handshake
//   s_tvalid/s_tready/s_tdata              : input sample stream
//   m_tvalid/m_tdata/m_tmode               : output stream, no backpressure
//   flt_srst/flt_ctrl/flt_s_tdata/flt_m_tdata : filter pins
//   busy, out_cnt                          : status
// ---------------------------------------------------------------------------
interface adaptive_filter_ctrl_if
  import adaptive_filter_pkg::*;
#(
  parameter int DATA_WIDTH = Q_WIDTH
);

  logic                  mode_req_valid;
  logic                  mode_req;
  logic                  mode_req_ready;
  logic                  s_tvalid;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  m_tvalid;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tmode;
  logic                  flt_srst;
  logic                  flt_ctrl;
  logic [DATA_WIDTH-1:0] flt_s_tdata;
  logic [DATA_WIDTH-1:0] flt_m_tdata;
  logic                  busy;
  logic [15:0]           out_cnt;

  modport master (
    input  mode_req_valid, mode_req, s_tvalid, s_tdata, flt_m_tdata,
    output mode_req_ready, s_tready, m_tvalid, m_tdata, m_tmode,
           flt_srst, flt_ctrl, flt_s_tdata, busy, out_cnt
  );

  modport slave (
    output mode_req_valid, mode_req, s_tvalid, s_tdata, flt_m_tdata,
    input  mode_req_ready, s_tready, m_tvalid, m_tdata, m_tmode,
           flt_srst, flt_ctrl, flt_s_tdata, busy, out_cnt
  );

endinterface

// File: rtl/adaptive_filter_ctrl_valid_delay_line.sv
// ---------------------------------------------------------------------------
// valid_delay_line
// Shift register that delays a single valid flag by DEPTH cycles so it lines
// up with data travelling through a fixed-latency datapath.
//   clk    : clock, rising edge
//   srst_n : synchronous clear, active low
//   d_i    : flag entering the line
//   q_o    : flag DEPTH cycles later
// ---------------------------------------------------------------------------
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic srst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] pipe_q;

  // Each stage copies its predecessor every cycle; a clear empties the whole
  // line so nothing that was in flight survives a reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/adaptive_filter_ctrl.sv
// ---------------------------------------------------------------------------
// adaptive_filter_ctrl
// Sequencer in front of the free-running adaptive filter. Owns the filter's
// reset and mode pins, turns the raw filter into a valid/ready stream, and
// performs mode changes as drain -> flush -> reopen.
//   clk    : clock, rising edge
//   srst_n : synchronous reset, active low
//   bus    : adaptive_filter_ctrl_if.master (streams, request, filter pins,
//            busy and out_cnt status)
// ---------------------------------------------------------------------------
module adaptive_filter_ctrl
  import adaptive_filter_pkg::*;
#(
  parameter int   DATA_WIDTH        = Q_WIDTH,
  parameter int   FRACTIONAL_LENGTH = Q_FRAC,
  parameter int   FILTER_LATENCY    = 1,
  parameter int   FLUSH_CYCLES      = 4,
  parameter logic MODE_RST          = MODE_INT
) (
  input  logic                  clk,
  input  logic                  srst_n,
  adaptive_filter_ctrl_if.master bus
);

  localparam int DRAIN_CYCLES = FILTER_LATENCY + 2;
  localparam int PIPE_DEPTH   = FILTER_LATENCY + 1;
  localparam int CNT_MAX      = maxInt(FLUSH_CYCLES, DRAIN_CYCLES);
  localparam int CNT_WIDTH    = $clog2(CNT_MAX + 1);

  // Reject parameter sets the sequencer cannot honour.
  if (FLUSH_CYCLES < 1) begin : gBadFlushCycles
    $error("adaptive_filter_ctrl: FLUSH_CYCLES must be at least 1");
  end
  if (FRACTIONAL_LENGTH >= DATA_WIDTH) begin : gBadFracLength
    $error("adaptive_filter_ctrl: FRACTIONAL_LENGTH must be below DATA_WIDTH");
  end

  ctrlState_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  pendMode_q, pendMode_d;
  logic                  sReady;
  logic                  reqReady;
  logic                  accept;
  logic                  pipeOut;
  logic [DATA_WIDTH-1:0] fltSData_q;
  logic [DATA_WIDTH-1:0] mTData_q;
  logic                  mTValid_q;
  logic [15:0]           outCnt_q;

  // State register. Reset parks the sequencer in FLUSH with a full flush
  // count and forgets any pending mode, so a reset mid-change simply
  // restarts in the reset mode.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q    <= FLUSH;
      cnt_q      <= CNT_WIDTH'(FLUSH_CYCLES);
      mode_q     <= MODE_RST;
      pendMode_q <= MODE_RST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      pendMode_q <= pendMode_d;
    end
  end

  // Next-state logic. One counter serves both timed phases: it is loaded on
  // entry and the phase ends in the cycle it reads one. The new mode only
  // reaches the filter when FLUSH starts, after the old-mode samples have
  // left the output register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    pendMode_d = pendMode_q;
    unique case (state_q)
      FLUSH: begin
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      RUN: begin
        if (reqReady && (bus.mode_req != mode_q)) begin
          pendMode_d = bus.mode_req;
          cnt_d      = CNT_WIDTH'(DRAIN_CYCLES);
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = FLUSH;
          cnt_d   = CNT_WIDTH'(FLUSH_CYCLES);
          mode_d  = pendMode_q;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = CNT_WIDTH'(FLUSH_CYCLES);
      end
    endcase
  end

  // FSM outputs. Both ready signals are masked by reset so a request or
  // sample presented while srst_n is low is never acknowledged.
  always_comb begin
    sReady       = srst_n && (state_q == RUN);
    reqReady     = sReady && bus.mode_req_valid;
    accept       = sReady && bus.s_tvalid;
    bus.s_tready       = sReady;
    bus.mode_req_ready = reqReady;
    bus.flt_srst       = (state_q == FLUSH);
    bus.busy           = (state_q != RUN);
  end

  // Tracks which filter input cycles carried a real sample, so the filter
  // output can be tagged valid once it has crossed the filter.
  valid_delay_line #(
    .DEPTH (PIPE_DEPTH)
  ) u_validPipe (
    .clk    (clk),
    .srst_n (srst_n),
    .d_i    (accept),
    .q_o    (pipeOut)
  );

  // Sample path and output count. Cycles without an accepted sample feed the
  // filter zero. The output register only loads on a tagged sample so the
  // last value is held otherwise. The count restarts on every FLUSH entry
  // and sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      fltSData_q <= '0;
      mTValid_q  <= 1'b0;
      mTData_q   <= '0;
      outCnt_q   <= '0;
    end else begin
      fltSData_q <= accept ? bus.s_tdata : '0;
      mTValid_q  <= pipeOut;
      if (pipeOut) begin
        mTData_q <= bus.flt_m_tdata;
      end
      if ((state_q != FLUSH) && (state_d == FLUSH)) begin
        outCnt_q <= '0;
      end else if (pipeOut && (outCnt_q != 16'hFFFF)) begin
        outCnt_q <= outCnt_q + 16'd1;
      end
    end
  end

  assign bus.flt_ctrl    = mode_q;
  assign bus.m_tmode     = mode_q;
  assign bus.flt_s_tdata = fltSData_q;
  assign bus.m_tvalid    = mTValid_q;
  assign bus.m_tdata     = mTData_q;
  assign bus.out_cnt     = outCnt_q;

endmodule

// File: tb/tb_adaptive_filter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adaptive_filter_ctrl
// Directed bench for the filter sequencer. A small behavioural filter
// (integrator / differentiator, one cycle latency) sits on the filter pins;
// expected values below are worked out by hand from the stimulus.
// ---------------------------------------------------------------------------
module tb_adaptive_filter_ctrl;
  import adaptive_filter_pkg::*;

  logic clk;
  logic srstN;
  int   checkCount;
  int   failCount;
  int   expData;
  int   expCnt;

  logic signed [13:0] fltAcc;
  logic signed [13:0] fltPrev;
  logic signed [13:0] fltOut;

  adaptive_filter_ctrl_if #(.DATA_WIDTH(14)) bus ();

  adaptive_filter_ctrl #(
    .DATA_WIDTH        (14),
    .FRACTIONAL_LENGTH (6),
    .FILTER_LATENCY    (1),
    .FLUSH_CYCLES      (4),
    .MODE_RST          (MODE_INT)
  ) dut (
    .clk    (clk),
    .srst_n (srstN),
    .bus    (bus)
  );

  // Free-running 100 MHz style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the real filter: registered output, cleared by flt_srst,
  // accumulating in integrator mode and taking first differences otherwise.
  always @(posedge clk) begin
    if (bus.flt_srst) begin
      fltAcc  <= '0;
      fltPrev <= '0;
      fltOut  <= '0;
    end else if (bus.flt_ctrl) begin
      fltAcc <= fltAcc + bus.flt_s_tdata;
      fltOut <= fltAcc + bus.flt_s_tdata;
    end else begin
      fltOut  <= bus.flt_s_tdata - fltPrev;
      fltPrev <= bus.flt_s_tdata;
    end
  end
  assign bus.flt_m_tdata = fltOut;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the sample source and the mode requester.
  task automatic applyStimulus(input logic sValid, input logic [13:0] sData,
                               input logic reqValid, input logic reqMode);
    bus.s_tvalid       = sValid;
    bus.s_tdata        = sData;
    bus.mode_req_valid = reqValid;
    bus.mode_req       = reqMode;
  endtask

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    srstN      = 1'b0;
    applyStimulus(1'b0, 14'h0000, 1'b1, MODE_DIFF);
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_flt_srst", bus.flt_srst, 1'b1);
    checkOutput("rst_s_tready", bus.s_tready, 1'b0);
    checkOutput("rst_req_ready", bus.mode_req_ready, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b1);
    checkOutput("rst_m_tvalid", bus.m_tvalid, 1'b0);
    checkOutput("rst_m_tdata", bus.m_tdata, 14'h0000);
    checkOutput("rst_flt_s_tdata", bus.flt_s_tdata, 14'h0000);
    checkOutput("rst_out_cnt", bus.out_cnt, 16'h0000);
    checkOutput("rst_flt_ctrl", bus.flt_ctrl, MODE_INT);
    checkOutput("rst_m_tmode", bus.m_tmode, MODE_INT);

    $display("[TB] release and integrate 1.0");
    srstN = 1'b1;
    applyStimulus(1'b1, 14'h0040, 1'b0, MODE_INT);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("release_s_tready", bus.s_tready, (i == 4));
    end
    checkOutput("release_flt_srst", bus.flt_srst, 1'b0);
    tick();
    checkOutput("first_flt_s_tdata", bus.flt_s_tdata, 14'h0040);
    checkOutput("lat_m_tvalid_1", bus.m_tvalid, 1'b0);
    tick();
    checkOutput("lat_m_tvalid_2", bus.m_tvalid, 1'b0);
    expData = 0;
    expCnt  = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expData += 'h40;
      expCnt++;
      checkOutput("ramp_m_tvalid", bus.m_tvalid, 1'b1);
      checkOutput("ramp_m_tdata", bus.m_tdata, expData);
      checkOutput("ramp_out_cnt", bus.out_cnt, expCnt);
    end

    $display("[TB] same-mode request");
    applyStimulus(1'b1, 14'h0040, 1'b1, MODE_INT);
    #1;
    checkOutput("same_req_ready", bus.mode_req_ready, 1'b1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      applyStimulus(1'b1, 14'h0040, 1'b0, MODE_INT);
      #1;
      expData += 'h40;
      expCnt++;
      checkOutput("same_req_ready_drop", bus.mode_req_ready, 1'b0);
      checkOutput("same_busy", bus.busy, 1'b0);
      checkOutput("same_m_tvalid", bus.m_tvalid, 1'b1);
      checkOutput("same_m_tdata", bus.m_tdata, expData);
      checkOutput("same_out_cnt", bus.out_cnt, expCnt);
    end

    $display("[TB] switch to differentiator");
    applyStimulus(1'b1, 14'h0040, 1'b1, MODE_DIFF);
    #1;
    checkOutput("sw_req_ready", bus.mode_req_ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) applyStimulus(1'b1, 14'h0040, 1'b0, MODE_INT);
      checkOutput("sw_s_tready", bus.s_tready, (k == 8));
      checkOutput("sw_flt_srst", bus.flt_srst, (k >= 4 && k <= 7));
      checkOutput("sw_busy", bus.busy, (k != 8));
      if (k <= 3) begin
        expData += 'h40;
        expCnt++;
        checkOutput("trail_m_tvalid", bus.m_tvalid, 1'b1);
        checkOutput("trail_m_tdata", bus.m_tdata, expData);
        checkOutput("trail_m_tmode", bus.m_tmode, MODE_INT);
        checkOutput("trail_out_cnt", bus.out_cnt, expCnt);
      end
      if (k == 4) begin
        checkOutput("flush_m_tvalid", bus.m_tvalid, 1'b0);
        checkOutput("flush_m_tdata_hold", bus.m_tdata, 14'h0200);
        checkOutput("flush_out_cnt", bus.out_cnt, 16'h0000);
        checkOutput("flush_flt_ctrl", bus.flt_ctrl, MODE_DIFF);
        checkOutput("flush_m_tmode", bus.m_tmode, MODE_DIFF);
      end
    end
    tick();
    tick();
    checkOutput("diff_gap_m_tvalid", bus.m_tvalid, 1'b0);
    checkOutput("diff_gap_m_tdata", bus.m_tdata, 14'h0200);
    tick();
    checkOutput("diff_step_m_tvalid", bus.m_tvalid, 1'b1);
    checkOutput("diff_step_m_tdata", bus.m_tdata, 14'h0040);
    checkOutput("diff_step_m_tmode", bus.m_tmode, MODE_DIFF);
    checkOutput("diff_step_out_cnt", bus.out_cnt, 16'd1);
    tick();
    checkOutput("diff_flat_m_tdata", bus.m_tdata, 14'h0000);
    checkOutput("diff_flat_out_cnt", bus.out_cnt, 16'd2);

    $display("[TB] request held through drain and flush");
    applyStimulus(1'b1, 14'h0040, 1'b1, MODE_INT);
    #1;
    checkOutput("held_first_ready", bus.mode_req_ready, 1'b1);
    tick();
    applyStimulus(1'b1, 14'h0040, 1'b1, MODE_DIFF);
    for (int k = 1; k <= 7; k++) begin
      #1;
      checkOutput("held_ready_low", bus.mode_req_ready, 1'b0);
      checkOutput("held_busy", bus.busy, 1'b1);
      tick();
    end
    checkOutput("held_ready_run", bus.mode_req_ready, 1'b1);
    checkOutput("held_s_tready_run", bus.s_tready, 1'b1);
    checkOutput("held_m_tmode_run", bus.m_tmode, MODE_INT);
    tick();
    applyStimulus(1'b1, 14'h0040, 1'b0, MODE_INT);
    #1;
    checkOutput("held_accepted_busy", bus.busy, 1'b1);
    checkOutput("held_accepted_ready", bus.mode_req_ready, 1'b0);

    $display("[TB] reset during drain");
    tick();
    srstN = 1'b0;
    applyStimulus(1'b1, 14'h0040, 1'b1, MODE_DIFF);
    #1;
    checkOutput("drain_rst_req_ready", bus.mode_req_ready, 1'b0);
    tick();
    checkOutput("drain_rst_flt_srst", bus.flt_srst, 1'b1);
    checkOutput("drain_rst_m_tvalid", bus.m_tvalid, 1'b0);
    checkOutput("drain_rst_m_tdata", bus.m_tdata, 14'h0000);
    checkOutput("drain_rst_out_cnt", bus.out_cnt, 16'h0000);
    checkOutput("drain_rst_flt_ctrl", bus.flt_ctrl, MODE_INT);
    checkOutput("drain_rst_busy", bus.busy, 1'b1);
    srstN = 1'b1;
    applyStimulus(1'b1, 14'h0040, 1'b0, MODE_INT);
    repeat (4) tick();
    checkOutput("post_rst_s_tready", bus.s_tready, 1'b1);
    checkOutput("post_rst_m_tmode", bus.m_tmode, MODE_INT);

    $display("[TB] long stream for count saturation");
    tick();
    tick();
    for (int n = 1; n <= 65540; n++) begin
      tick();
      if (n == 1) checkOutput("sat_first_m_tdata", bus.m_tdata, 14'h0040);
      if (n == 2) checkOutput("sat_second_m_tdata", bus.m_tdata, 14'h0080);
      if (n == 65534) checkOutput("sat_cnt_fffe", bus.out_cnt, 16'hFFFE);
      if (n == 65535) checkOutput("sat_cnt_ffff", bus.out_cnt, 16'hFFFF);
      if (n == 65540) begin
        checkOutput("sat_cnt_hold", bus.out_cnt, 16'hFFFF);
        checkOutput("sat_m_tvalid", bus.m_tvalid, 1'b1);
      end
    end

    $display("[TB] reset together with a request in RUN");
    srstN = 1'b0;
    applyStimulus(1'b1, 14'h0040, 1'b1, MODE_DIFF);
    #1;
    checkOutput("run_rst_req_ready", bus.mode_req_ready, 1'b0);
    checkOutput("run_rst_s_tready", bus.s_tready, 1'b0);
    tick();
    checkOutput("run_rst_busy", bus.busy, 1'b1);
    checkOutput("run_rst_flt_srst", bus.flt_srst, 1'b1);
    checkOutput("run_rst_out_cnt", bus.out_cnt, 16'h0000);
    checkOutput("run_rst_flt_ctrl", bus.flt_ctrl, MODE_INT);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
